// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-redirect flush,
// memory-wait stall with timeout, and saturating stall/flush counters.
// Outputs are a combinational decode of state and current inputs and are
// forced to zero while rst is high.
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_is_load,
  input  logic        ex_write_reg,
  input  logic [4:0]  ex_dst,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        pc_redirect,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        merr_q, merr_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic lu, mem_wait;
  logic s_if, s_id, s_ex, bex, fid, pcr;

  // Hazard detection on the current decode/execute pair
  always_comb begin
    lu = ex_is_load & ex_write_reg & (ex_dst != 5'd0) &
         ((id_use_rs1 & (id_rs1 == ex_dst)) | (id_use_rs2 & (id_rs2 == ex_dst)));
    mem_wait = mem_req & ~mem_ready;
  end

  // Next-state and raw output decode
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    merr_d  = merr_q;
    s_if    = 1'b0;
    s_id    = 1'b0;
    s_ex    = 1'b0;
    bex     = 1'b0;
    fid     = 1'b0;
    pcr     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          s_if    = 1'b1;
          s_id    = 1'b1;
          s_ex    = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = 16'd1;
        end else if (ex_redirect) begin
          pcr = 1'b1;
          fid = 1'b1;
          bex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = 4'(FLUSH_CYCLES - 1);
          end
        end else if (lu) begin
          s_if = 1'b1;
          s_id = 1'b1;
          bex  = 1'b1;
        end
      end
      FLUSH: begin
        fid = 1'b1;
        bex = 1'b1;
        if (mem_wait) begin
          // Memory stall freezes the remaining flush count
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
        end else if (fcnt_q <= 4'd1) begin
          fcnt_d  = '0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
          if (wcnt_q == 16'(MEM_TIMEOUT)) begin
            merr_d  = 1'b1;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating performance counter next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (s_if && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (pcr && flush_cnt_q != 16'hFFFF)  flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Registered state, counts and sticky error; synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      wcnt_q      <= '0;
      merr_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wcnt_q      <= wcnt_d;
      merr_q      <= merr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output gating: everything reads zero while reset is asserted
  always_comb begin
    stall_if    = ~rst & s_if;
    stall_id    = ~rst & s_id;
    stall_ex    = ~rst & s_ex;
    bubble_ex   = ~rst & bex;
    flush_id    = ~rst & fid;
    pc_redirect = ~rst & pcr;
    mem_err     = ~rst & merr_q;
    stall_cnt   = rst ? '0 : stall_cnt_q;
    flush_cnt   = rst ? '0 : flush_cnt_q;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush_id/bubble_ex are held after a taken redirect (legal 1..15).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the MEM_WAIT cycle limit before mem_err is raised (legal 1..65535).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs1, id_rs2  in  5 each  decode-stage source register addresses.
REQ-007 id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1 / rs2.
REQ-008 ex_is_load  in  1  execute-stage instruction is a load (info_load nonzero).
REQ-009 ex_write_reg, ex_dst  in  1, 5  execute-stage register write enable and destination.
REQ-010 ex_redirect  in  1  execute-stage next_pc differs from pc+4 (branch/jump taken).
REQ-011 mem_req, mem_ready  in  1 each  memory-stage access request and its completion.
REQ-012 stall_if, stall_id, stall_ex  out  1 each  hold the fetch, decode and execute pipeline registers.
REQ-013 bubble_ex  out  1  load a NOP into the execute input (write_reg=0, info_*=0).
REQ-014 flush_id  out  1  squash the decode-stage instruction.
REQ-015 pc_redirect  out  1  select the execute-stage next_pc as the fetch address.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-018 The FSM SHALL have states RUN, FLUSH and MEM_WAIT.
REQ-019 Outputs SHALL be a combinational decode of state and current inputs; state and counters SHALL be registered.
REQ-020 Hazard lu SHALL be defined as ex_is_load & ex_write_reg & (ex_dst!=0) & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst)).
REQ-021 Priority in RUN SHALL be memory wait > redirect > load-use.
REQ-022 RUN with mem_req & !mem_ready: stall_if=stall_id=stall_ex=1, pc_redirect=0; the next state SHALL be MEM_WAIT with the wait counter set to 1.
REQ-023 RUN with ex_redirect and no memory wait: pc_redirect=1, flush_id=1, bubble_ex=1; if FLUSH_CYCLES>1 the next state SHALL be FLUSH with remaining count FLUSH_CYCLES-1, else RUN.
REQ-024 RUN with lu only: stall_if=stall_id=1, bubble_ex=1 for that cycle; the state SHALL remain RUN (single bubble, no registered state).
REQ-025 FLUSH: flush_id=bubble_ex=1; ex_redirect and lu SHALL be ignored; the count decrements each cycle; exit to RUN when the count reaches 0.
REQ-026 FLUSH with mem_req & !mem_ready: stalls SHALL take precedence (stall_* =1, flush held), the count SHALL freeze, and the state SHALL remain FLUSH.
REQ-027 MEM_WAIT: stall_if=stall_id=stall_ex=1; pc_redirect, flush_id and bubble_ex SHALL be 0.
REQ-028 MEM_WAIT exit: on mem_ready the stalls SHALL drop in that same cycle and the next state SHALL be RUN.
REQ-029 ex_redirect held during MEM_WAIT SHALL be acted on in the first RUN cycle after the wait.
REQ-030 MEM_WAIT timeout: when the wait counter equals MEM_TIMEOUT without mem_ready, mem_err SHALL set and the next state SHALL be RUN.
REQ-031 The wait counter SHALL be 16 bits, incrementing once per MEM_WAIT cycle.
REQ-032 stall_cnt SHALL increment on each cycle with stall_if=1; flush_cnt SHALL increment on each cycle with pc_redirect=1.
REQ-033 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF.
REQ-034 mem_err SHALL clear only on rst.

Reset
REQ-035 While rst=1, all outputs SHALL be 0 regardless of other inputs.
REQ-036 On the clock edge with rst=1, the state SHALL become RUN, and all counts, counters and mem_err SHALL clear.
REQ-037 rst asserted in FLUSH or MEM_WAIT SHALL abandon the operation; there SHALL be no carry-over of redirect or stall.

Verification
REQ-038 Load-use: ex_is_load=1, ex_write_reg=1, ex_dst=5, id_use_rs2=1, id_rs2=5 -> one cycle of stall_if=stall_id=bubble_ex=1; stall_cnt=1. Repeat with ex_dst=0 -> no stall.
REQ-039 Redirect: ex_redirect=1 for one cycle, FLUSH_CYCLES=2 -> pc_redirect=1 for 1 cycle; flush_id=bubble_ex=1 for 2 cycles; flush_cnt=1; lu raised in cycle 2 is ignored.
REQ-040 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> stall_* high for 3 cycles, low in the mem_ready cycle; stall_cnt=3.
REQ-041 Simultaneous events: mem wait and ex_redirect together -> no pc_redirect during the wait; pc_redirect=1 in the first cycle after mem_ready.
REQ-042 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 4 MEM_WAIT cycles, then state RUN; mem_err stays 1 until rst.
REQ-043 Reset and saturation: rst mid-FLUSH -> outputs 0 on the next cycle; separately, force 70000 stall cycles -> stall_cnt=16'hFFFF.
